seven_segment_decoder: RTL and testbench

SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

---
 rtl/seven_segment_decoder.sv | 257 +++++++++++++++++++++++++
 tb/tb_seven_segment_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_decoder
//
// Purpose:
//    Debounces and decodes a two-digit, active-low seven-segment display
//    pattern (tens + units) into a binary value 0..59. A pattern must be
//    sampled STABLE_CYCLES times in a row before it is decoded. A pattern
//    identical to the last one handed to the consumer is suppressed, so a
//    static display produces exactly one result. Illegal digit codes, or a
//    tens digit above 5, are reported through bad_pattern with value = 0.
//
// Parameters:
//    STABLE_CYCLES  consecutive identical accepted samples needed (1..15)
//
// Ports:
//    clk          in   sole clock, rising edge
//    reset        in   asynchronous, active-high reset
//    segment      in   [0:13] bits 0..6 tens a..g, bits 7..13 units a..g
//                      (0 = segment lit)
//    seg_valid    in   segment carries a sample this cycle
//    seg_ready    out  sample accepted this cycle (low while a result waits)
//    value        out  [0:5] decoded value 0..59, bit 0 = MSB
//    value_valid  out  value / bad_pattern are valid
//    value_ready  in   consumer takes the result this cycle
//    bad_pattern  out  emitted pattern is not a legal 00..59 display
//    err_count    out  [7:0] saturating count of bad results taken
//
// Configuration:
//    SSD_ERR_COUNT_EN  when defined, err_count counts bad results handed to
//                      the consumer (saturating at 255); when undefined the
//                      counter is not built and err_count is tied to 0.
// -----------------------------------------------------------------------------
module seven_segment_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [0:13] segment,
   input  logic        seg_valid,
   output logic        seg_ready,
   output logic [0:5]  value,
   output logic        value_valid,
   input  logic        value_ready,
   output logic        bad_pattern,
   output logic [7:0]  err_count
);

   localparam logic [3:0] STABLE_LIM = STABLE_CYCLES[3:0];

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_EMIT
   } state_t;

   // Decoded form of one digit: legal flag plus binary digit.
   typedef struct packed {
      logic       legal;
      logic [3:0] digit;
   } digit_t;

   // Decoded form of a whole two-digit pattern.
   typedef struct packed {
      logic       bad;
      logic [5:0] value;
   } result_t;

   // Segment order a..g, a in the MSB, active-low.
   function automatic digit_t decode_digit(input logic [6:0] code);
      digit_t d;
      d.legal = 1'b1;
      d.digit = 4'd0;
      case (code)
         7'b0000001: d.digit = 4'd0;
         7'b1001111: d.digit = 4'd1;
         7'b0010010: d.digit = 4'd2;
         7'b0000110: d.digit = 4'd3;
         7'b1001100: d.digit = 4'd4;
         7'b0100100: d.digit = 4'd5;
         7'b0100000: d.digit = 4'd6;
         7'b0001111: d.digit = 4'd7;
         7'b0000000: d.digit = 4'd8;
         7'b0000100: d.digit = 4'd9;
         default:    d.legal = 1'b0;
      endcase
      return d;
   endfunction

   function automatic result_t decode_pattern(input logic [13:0] pat);
      digit_t     tens;
      digit_t     units;
      logic [5:0] tens6;
      result_t    r;
      tens  = decode_digit(pat[13:7]);
      units = decode_digit(pat[6:0]);
      tens6 = {2'b00, tens.digit};
      if (tens.legal && units.legal && (tens.digit <= 4'd5)) begin
         r.bad   = 1'b0;
         // 10*tens as (8 + 2)*tens keeps the arithmetic 6 bits wide.
         r.value = (tens6 << 3) + (tens6 << 1) + {2'b00, units.digit};
      end else begin
         r.bad   = 1'b1;
         r.value = 6'd0;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t      state_q,     state_d;
   logic [13:0] cand_q,      cand_d;
   logic [3:0]  stab_cnt_q,  stab_cnt_d;
   logic [13:0] last_q,      last_d;
   logic        last_vld_q,  last_vld_d;   // low = nothing emitted since reset
   logic [5:0]  value_q,     value_d;
   logic        bad_q,       bad_d;

   logic        accept;
   logic        stable_done;
   logic [13:0] seg_pat;
   logic [3:0]  cnt_next;
   result_t     seg_result;
   logic        handshake;

   // Port order [0:13] lands segment[0] (tens a) on seg_pat[13].
   assign seg_pat    = segment;
   assign seg_result = decode_pattern(seg_pat);

   assign seg_ready   = (state_q != ST_EMIT);
   // Pure decode of the state flop, so reset drops it without a clock edge.
   assign value_valid = (state_q == ST_EMIT);
   assign value       = value_q;
   assign bad_pattern = bad_q;
   assign accept      = seg_valid && seg_ready;
   assign handshake   = value_valid && value_ready;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      cand_d      = cand_q;
      stab_cnt_d  = stab_cnt_q;
      last_d      = last_q;
      last_vld_d  = last_vld_q;
      value_d     = value_q;
      bad_d       = bad_q;
      stable_done = 1'b0;
      cnt_next    = 4'd1;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cand_d     = seg_pat;
               stab_cnt_d = 4'd1;
               if (STABLE_LIM <= 4'd1) begin
                  stable_done = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
         end

         ST_SETTLE: begin
            if (accept) begin
               if (seg_pat == cand_q) begin
                  cnt_next = stab_cnt_q + 4'd1;
               end else begin
                  cand_d   = seg_pat;
                  cnt_next = 4'd1;
               end
               stab_cnt_d = cnt_next;
               if (cnt_next >= STABLE_LIM) begin
                  stable_done = 1'b1;
               end
            end
         end

         ST_EMIT: begin
            // value_q / bad_q hold by default while the consumer stalls.
            if (value_ready) begin
               last_d     = cand_q;
               last_vld_d = 1'b1;
               state_d    = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // The stable pattern is always the current sample: either it matched
      // the candidate or it just became the candidate.
      if (stable_done) begin
         if (last_vld_q && (seg_pat == last_q)) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_EMIT;
            value_d = seg_result.value;
            bad_d   = seg_result.bad;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cand_q     <= '0;
         stab_cnt_q <= '0;
         last_q     <= '0;
         last_vld_q <= 1'b0;
         value_q    <= '0;
         bad_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q    <= state_d;
         cand_q     <= cand_d;
         stab_cnt_q <= stab_cnt_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         value_q    <= value_d;
         bad_q      <= bad_d;
      end
   end

   // ---------------------------------------------------------------------
   // Bad-result counter
   // ---------------------------------------------------------------------
`ifdef SSD_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (handshake && bad_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`else
   logic unused_handshake;
   assign unused_handshake = handshake;
   assign err_count        = 8'd0;
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_decoder
//
// Directed bench for seven_segment_decoder with STABLE_CYCLES = 4.
// Inputs change 1 ns after the rising edge; outputs are compared at that
// same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_seven_segment_decoder;

   localparam int STABLE = 4;

   // Digit codes a..g, a in the MSB, active-low.
   localparam logic [6:0] D0 = 7'b0000001;
   localparam logic [6:0] D1 = 7'b1001111;
   localparam logic [6:0] D2 = 7'b0010010;
   localparam logic [6:0] D3 = 7'b0000110;
   localparam logic [6:0] D4 = 7'b1001100;
   localparam logic [6:0] D5 = 7'b0100100;
   localparam logic [6:0] D6 = 7'b0100000;
   localparam logic [6:0] D7 = 7'b0001111;
   localparam logic [6:0] D8 = 7'b0000000;
   localparam logic [6:0] D9 = 7'b0000100;
   localparam logic [6:0] DX = 7'b1111111;   // blank: illegal

   logic        clk;
   logic        reset;
   logic [0:13] segment;
   logic        seg_valid;
   logic        seg_ready;
   logic [0:5]  value;
   logic        value_valid;
   logic        value_ready;
   logic        bad_pattern;
   logic [7:0]  err_count;

   int checks;
   int errors;
   int bad_taken;

   seven_segment_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .reset       (reset),
      .segment     (segment),
      .seg_valid   (seg_valid),
      .seg_ready   (seg_ready),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .bad_pattern (bad_pattern),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [13:0] pat;
      logic [5:0]  exp_value;
      logic        exp_bad;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present pat as a valid sample for n cycles, then drop seg_valid.
   task automatic drive(input logic [13:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         segment   = pat;
         seg_valid = 1'b1;
         tick();
      end
      seg_valid = 1'b0;
   endtask

   function automatic logic [7:0] exp_err(input int n);
`ifdef SSD_ERR_COUNT_EN
      return (n > 255) ? 8'd255 : n[7:0];
`else
      return (n > 255) ? 8'd0 : 8'd0;
`endif
   endfunction

   initial begin
      logic [13:0] seq30[8];

      checks    = 0;
      errors    = 0;
      bad_taken = 0;

      vecs[0] = '{{D0, D0}, 6'd0,  1'b0};
      vecs[1] = '{{D5, D9}, 6'd59, 1'b0};
      vecs[2] = '{{D0, D7}, 6'd7,  1'b0};
      vecs[3] = '{{D1, D8}, 6'd18, 1'b0};
      vecs[4] = '{{D9, D9}, 6'd0,  1'b1};
      vecs[5] = '{{D3, D1}, 6'd31, 1'b0};
      vecs[6] = '{{D2, DX}, 6'd0,  1'b1};
      vecs[7] = '{{D4, D2}, 6'd42, 1'b0};

      segment     = '0;
      seg_valid   = 1'b0;
      value_ready = 1'b1;
      reset       = 1'b1;
      #1;
      check("reset_valid",   32'(value_valid), 32'd0);
      check("reset_ready",   32'(seg_ready),   32'd1);
      check("reset_value",   32'(value),       32'd0);
      check("reset_bad",     32'(bad_pattern), 32'd0);
      check("reset_err",     32'(err_count),   32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // 23 stable for 4 cycles: result in the cycle after the fourth sample.
      for (int i = 0; i < STABLE; i++) begin
         check("p23_no_early_valid", 32'(value_valid), 32'd0);
         segment   = {D2, D3};
         seg_valid = 1'b1;
         tick();
      end
      seg_valid = 1'b0;
      check("p23_valid", 32'(value_valid), 32'd1);
      check("p23_value", 32'(value),       32'd23);
      check("p23_bad",   32'(bad_pattern), 32'd0);
      tick();
      check("p23_taken", 32'(value_valid), 32'd0);

      // Same pattern held: must not be emitted again.
      for (int i = 0; i < 10; i++) begin
         segment   = {D2, D3};
         seg_valid = 1'b1;
         tick();
         check("p23_no_repeat", 32'(value_valid), 32'd0);
      end
      seg_valid = 1'b0;

      // Table of patterns, each distinct from the one before.
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].pat, STABLE);
         check($sformatf("vec%0d_valid", v), 32'(value_valid), 32'd1);
         check($sformatf("vec%0d_value", v), 32'(value),       32'(vecs[v].exp_value));
         check($sformatf("vec%0d_bad",   v), 32'(bad_pattern), 32'(vecs[v].exp_bad));
         if (vecs[v].exp_bad) bad_taken++;
         tick();
         check($sformatf("vec%0d_taken", v), 32'(value_valid), 32'd0);
      end
      check("table_err_count", 32'(err_count), 32'(exp_err(bad_taken)));

      // 45 x3, 46 x1, 45 x4: one result, four samples after the last restart.
      seq30 = '{{D4, D5}, {D4, D5}, {D4, D5}, {D4, D6},
                {D4, D5}, {D4, D5}, {D4, D5}, {D4, D5}};
      for (int i = 0; i < 8; i++) begin
         segment   = seq30[i];
         seg_valid = 1'b1;
         tick();
         if (i < 7) check("p45_no_early_valid", 32'(value_valid), 32'd0);
      end
      seg_valid = 1'b0;
      check("p45_valid", 32'(value_valid), 32'd1);
      check("p45_value", 32'(value),       32'd45);
      check("p45_bad",   32'(bad_pattern), 32'd0);
      tick();
      check("p45_single", 32'(value_valid), 32'd0);
      tick();
      check("p45_single2", 32'(value_valid), 32'd0);

      // Tens digit 6 is illegal.
      drive({D6, D0}, STABLE);
      check("p60_valid", 32'(value_valid), 32'd1);
      check("p60_value", 32'(value),       32'd0);
      check("p60_bad",   32'(bad_pattern), 32'd1);
      bad_taken++;
      tick();
      check("p60_taken", 32'(value_valid), 32'd0);
      check("p60_err_count", 32'(err_count), 32'(exp_err(bad_taken)));

      // Back-pressure: 12 waits 5 cycles; samples offered meanwhile are ignored.
      value_ready = 1'b0;
      drive({D1, D2}, STABLE);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(value_valid), 32'd1);
         check("bp_ready", 32'(seg_ready),   32'd0);
         check("bp_value", 32'(value),       32'd12);
         check("bp_bad",   32'(bad_pattern), 32'd0);
         segment   = {D3, D4};
         seg_valid = 1'b1;
         tick();
      end
      seg_valid   = 1'b0;
      value_ready = 1'b1;
      check("bp_valid_at_take", 32'(value_valid), 32'd1);
      check("bp_value_at_take", 32'(value),       32'd12);
      tick();
      check("bp_taken",  32'(value_valid), 32'd0);
      check("bp_ready2", 32'(seg_ready),   32'd1);
      tick();
      check("bp_no_queued", 32'(value_valid), 32'd0);

      // Reset pulsed while 33 waits: valid drops at once, then 33 re-emitted.
      value_ready = 1'b0;
      drive({D3, D3}, STABLE);
      check("rst_pre_valid", 32'(value_valid), 32'd1);
      check("rst_pre_value", 32'(value),       32'd33);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_valid", 32'(value_valid), 32'd0);
      check("rst_async_ready", 32'(seg_ready),   32'd1);
      check("rst_async_value", 32'(value),       32'd0);
      check("rst_async_err",   32'(err_count),   32'd0);
      bad_taken = 0;
      tick();
      reset       = 1'b0;
      value_ready = 1'b1;
      tick();
      check("rst_post_idle", 32'(value_valid), 32'd0);
      drive({D3, D3}, STABLE);
      check("rst_re_valid", 32'(value_valid), 32'd1);
      check("rst_re_value", 32'(value),       32'd33);
      check("rst_re_bad",   32'(bad_pattern), 32'd0);
      tick();
      check("rst_re_taken", 32'(value_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
